u31_cfg_loader: RTL
===================

Name: u31_cfg_loader

Overview:
- Sequences one 3-input gate function (8-bit truth table) into a unigate cell's serial configuration chain.
- Sits directly downstream of the combinational function-to-wiring lookup.
- For each accepted request it walks pin indices 0..5, collects the six 3-bit wiring codes into an 18-bit word, shifts the word serially into the cell chain, then pulses latch.
- Skips the whole sequence when the requested function is already loaded.

Parameters:
- NPINS, 6, pins per cell; number of lookup cycles.
- WBITS, 3, wiring code width per pin.
- CFGW, 18, chain length; must equal NPINS*WBITS.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  function load request.
- req_func  in  8  truth table to load; sampled on handshake.
- req_ready  out  1  high only in IDLE.
- lut_func  out  8  function driven to the lookup; holds the captured request.
- lut_pin  out  3  pin index driven to the lookup.
- lut_wiring  in  3  lookup result for (lut_func, lut_pin); combinational, valid the same cycle.
- cfg_sdata  out  1  serial config data.
- cfg_sen  out  1  shift enable for the cell chain.
- cfg_latch  out  1  one-cycle pulse; the cell commits the chain.
- cfg_word  out  18  assembled wiring word; bits [3p+2:3p] = pin p.
- done  out  1  one-cycle pulse when a request completes, including skipped requests.
- loaded_func  out  8  function currently committed in the cell.
- loaded_valid  out  1  loaded_func is meaningful.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - State IDLE.
  - req_ready=1 once out of reset. Its value during the reset cycle is 0.
  - lut_func=0, lut_pin=0, cfg_sdata=0, cfg_sen=0, cfg_latch=0, cfg_word=0, done=0, loaded_func=0, loaded_valid=0.
- Reset mid-operation:
  - Aborts immediately, with no latch pulse.
  - Clears loaded_valid.
  - The cell contents are then unknown; the next request always performs a full load.
- Handshake:
  - Accept on the rising edge where req_valid && req_ready. Call that cycle T.
  - req_func is captured into lut_func. req_func may change freely after T.
- IDLE -> CHECK on accept.
- CHECK (cycle T+1):
  - If loaded_valid && lut_func==loaded_func: done=1 this cycle, then -> IDLE. There is no cfg_sen and no cfg_latch.
  - Otherwise -> FETCH with lut_pin=0.
- FETCH (cycles T+2..T+7):
  - lut_pin = 0,1,..,5 in successive cycles.
  - At the end of each cycle, cfg_word[3*lut_pin +: 3] <= lut_wiring.
  - After pin 5 -> SHIFT. lut_pin returns to 0.
- SHIFT (cycles T+8..T+25):
  - cfg_sen=1.
  - cfg_sdata = cfg_word[17-k] in shift cycle k = 0..17, i.e. MSB first.
  - The value is registered so it is stable for the whole cycle.
  - A 5-bit counter bounds the state at exactly 18 cycles.
- LATCH (cycle T+26):
  - cfg_sen=0, cfg_latch=1, done=1.
  - loaded_func <= lut_func and loaded_valid <= 1 at the end of the cycle.
  - Then -> IDLE; req_ready=1 from T+27.
- Latency: full load 27 cycles from accept to the next req_ready; skipped load 2 cycles.
- Back-to-back: a request held high in IDLE is accepted in the first IDLE cycle. There is no bubble beyond the IDLE cycle.
- cfg_word holds its last value outside FETCH. A skipped request does not modify it.
- lut_pin never exceeds 5. Values 6 and 7 are never driven.
- cfg_sen and cfg_latch are never high in the same cycle.
- done is never high outside CHECK or LATCH.

Test Plan:
- Reset, then request func=0x01:
  - cfg_word=0x22689 at the end of FETCH.
  - cfg_sdata sequence over 18 cycles is 1,0,0,0,1,0,0,1,1,0,1,0,0,0,1,0,0,1.
  - cfg_latch and done at T+26; loaded_func=0x01.
- Repeat func=0x01 immediately:
  - done at T+1 only, no cfg_sen or cfg_latch.
  - cfg_word stays 0x22689; req_ready again at T+2.
- Request func=0xFF, then func=0x00 back-to-back with req_valid held:
  - cfg_word=0x01000 then 0x00000.
  - Two latch pulses 27 cycles apart.
- Assert rst during SHIFT of func=0x0F:
  - No cfg_latch; all outputs are zero the next cycle; loaded_valid=0.
  - A following request for 0x0F performs a full load, not a skip.
- Random sweep of 256 functions against a lookup model:
  - Every serial stream matches model bits MSB first.
  - lut_pin stays within 0..5.
  - req_ready is low throughout each busy period.
- Change req_func while busy and hold req_valid low:
  - lut_func stays at the captured value until done.

Source files
------------

// File: rtl/u31_cfg_loader_if.sv
// Request, lookup and configuration-chain signals of the unigate config loader.
interface u31_cfg_loader_if #(
  parameter int unsigned WBITS = 3,
  parameter int unsigned CFGW  = 18
) ();
  logic             req_valid;
  logic             req_ready;
  logic [7:0]       req_func;
  logic [7:0]       lut_func;
  logic [2:0]       lut_pin;
  logic [WBITS-1:0] lut_wiring;
  logic             cfg_sdata;
  logic             cfg_sen;
  logic             cfg_latch;
  logic [CFGW-1:0]  cfg_word;
  logic             done;
  logic [7:0]       loaded_func;
  logic             loaded_valid;

  modport master (
    output req_valid, req_func, lut_wiring,
    input  req_ready, lut_func, lut_pin, cfg_sdata, cfg_sen, cfg_latch,
           cfg_word, done, loaded_func, loaded_valid
  );

  modport slave (
    input  req_valid, req_func, lut_wiring,
    output req_ready, lut_func, lut_pin, cfg_sdata, cfg_sen, cfg_latch,
           cfg_word, done, loaded_func, loaded_valid
  );
endinterface

// File: rtl/u31_cfg_loader.sv
// Loads one 3-input gate function into a unigate cell: look up six pin wiring
// codes, shift the 18-bit word MSB first into the cell chain, then latch it.
module u31_cfg_loader #(
  parameter int unsigned NPINS = 6,
  parameter int unsigned WBITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  u31_cfg_loader_if.slave  bus
);
  localparam int unsigned CFGW = NPINS * WBITS;
  localparam int unsigned FW   = 8;
  localparam int unsigned PINW = 3;
  localparam int unsigned CNTW = 5;

  typedef enum logic [2:0] {IDLE, CHECK, FETCH, SHIFT, LATCH} state_e;

  state_e          state_q;
  logic            req_ready_q;
  logic [FW-1:0]   lut_func_q;
  logic [PINW-1:0] lut_pin_q;
  logic            cfg_sdata_q;
  logic            cfg_sen_q;
  logic            cfg_latch_q;
  logic [CFGW-1:0] cfg_word_q;
  logic            done_q;
  logic [FW-1:0]   loaded_func_q;
  logic            loaded_valid_q;
  logic [CNTW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      req_ready_q    <= 1'b0;
      lut_func_q     <= '0;
      lut_pin_q      <= '0;
      cfg_sdata_q    <= 1'b0;
      cfg_sen_q      <= 1'b0;
      cfg_latch_q    <= 1'b0;
      cfg_word_q     <= '0;
      done_q         <= 1'b0;
      loaded_func_q  <= '0;
      loaded_valid_q <= 1'b0;
      cnt_q          <= '0;
    end else begin
      done_q      <= 1'b0;
      cfg_latch_q <= 1'b0;
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (bus.req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            lut_func_q  <= bus.req_func;
            // A hit is known at accept so done is already registered in CHECK
            done_q      <= loaded_valid_q && (bus.req_func == loaded_func_q);
            state_q     <= CHECK;
          end
        end
        CHECK: begin
          if (loaded_valid_q && (lut_func_q == loaded_func_q)) begin
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            lut_pin_q <= '0;
            state_q   <= FETCH;
          end
        end
        FETCH: begin
          for (int p = 0; p < NPINS; p++) begin
            if (lut_pin_q == PINW'(p)) cfg_word_q[p*WBITS +: WBITS] <= bus.lut_wiring;
          end
          if (lut_pin_q == PINW'(NPINS - 1)) begin
            // Word MSB comes from the pin being fetched this very cycle
            lut_pin_q   <= '0;
            cnt_q       <= '0;
            cfg_sen_q   <= 1'b1;
            cfg_sdata_q <= bus.lut_wiring[WBITS-1];
            state_q     <= SHIFT;
          end else begin
            lut_pin_q <= lut_pin_q + PINW'(1);
          end
        end
        SHIFT: begin
          if (cnt_q == CNTW'(CFGW - 1)) begin
            cfg_sen_q   <= 1'b0;
            cfg_sdata_q <= 1'b0;
            cfg_latch_q <= 1'b1;
            done_q      <= 1'b1;
            state_q     <= LATCH;
          end else begin
            cnt_q       <= cnt_q + CNTW'(1);
            cfg_sdata_q <= cfg_word_q[CNTW'(CFGW - 2) - cnt_q];
          end
        end
        LATCH: begin
          loaded_func_q  <= lut_func_q;
          loaded_valid_q <= 1'b1;
          req_ready_q    <= 1'b1;
          state_q        <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.lut_func     = lut_func_q;
  assign bus.lut_pin      = lut_pin_q;
  assign bus.cfg_sdata    = cfg_sdata_q;
  assign bus.cfg_sen      = cfg_sen_q;
  assign bus.cfg_latch    = cfg_latch_q;
  assign bus.cfg_word     = cfg_word_q;
  assign bus.done         = done_q;
  assign bus.loaded_func  = loaded_func_q;
  assign bus.loaded_valid = loaded_valid_q;
endmodule
